pattern_cmd_scheduler: RTL and testbench
========================================

# pattern_cmd_scheduler

Command scheduler for the pattern writer. It accepts transfer requests from NUM_REQ requesters and arbitrates between them round-robin. It splits each request into chunks of at most MAX_CHUNK bytes, drives the writer's 96-bit command sink, and tracks completion by monitoring accepted master write beats. It sits between the requesters (DMA/control logic) and pattern_writer, and keeps one command outstanding at a time.

## Interface
- NUM_REQ, 4, number of requesters (2–8)
- ADDRESS_WIDTH, 32, address width
- LENGTH_WIDTH, 32, byte-length width
- BYTE_ENABLE_WIDTH, 4, bytes per master beat (power of 2)
- MAX_CHUNK, 4096, max bytes per issued command; multiple of BYTE_ENABLE_WIDTH
- TIMEOUT_CYCLES, 1024, stall limit (only with SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-cycle grant/accept pulse
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  start byte address; requester i at slice i
- req_length  in  NUM_REQ*LENGTH_WIDTH  byte count; multiple of BYTE_ENABLE_WIDTH
- req_done  out  NUM_REQ  one-cycle completion pulse
- req_err  out  NUM_REQ  one-cycle abort pulse (timeout)
- cmd_data  out  96  {length[95:64], address[63:32], 32'h0}
- cmd_valid  out  1  command valid
- cmd_ready  in  1  writer accepts command
- mon_write  in  1  tap of master_write
- mon_waitrequest  in  1  tap of master_waitrequest
- busy  out  1  high outside IDLE
- grant_id  out  $clog2(NUM_REQ)  current owner; valid while busy

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_valid is set, pick the first set bit starting at rr_ptr, wrapping.
  - Pulse req_ready[i] for that cycle and latch addr and remaining=length.
  - If length==0: go to DONE directly with no command. Otherwise go to ISSUE.
  - Set rr_ptr = i+1 mod NUM_REQ.
- ISSUE: chunk = min(remaining, MAX_CHUNK).
  - Hold cmd_valid=1 with cmd_data stable until cmd_ready.
  - On the handshake: beats_left = chunk/BYTE_ENABLE_WIDTH, go to WAIT.
- WAIT: each cycle with mon_write & ~mon_waitrequest decrements beats_left.
  - When the last beat is accepted: addr += chunk, remaining -= chunk.
  - Then go to ISSUE if remaining != 0, else go to DONE.
- DONE: pulse req_done[grant_id] for one cycle, then go to IDLE.
- Arithmetic is unsigned. addr wraps modulo 2^ADDRESS_WIDTH without error.
- Requesters hold req_addr/req_length stable while req_valid=1 and until req_ready. Deasserting req_valid before grant withdraws the request.
- A beat observed outside WAIT is ignored.

## Timing
- Reset values: req_ready=0, req_done=0, req_err=0, cmd_valid=0, cmd_data=0, busy=0, grant_id=0, rr_ptr=0, state=IDLE.
- Grant latency: req_valid seen in IDLE → req_ready that same cycle (combinational from registered state and rr_ptr) → cmd_valid on the next cycle.
- Last beat accepted → cmd_valid for the next chunk, or req_done, on the next cycle.
- cmd_ready may already be high when cmd_valid rises; the handshake then completes in one cycle.
- A new request is not sampled in the DONE cycle. Minimum gap between grants is 1 cycle after req_done.
- Asserting reset mid-transfer aborts immediately with no done or err pulse. Outputs return to reset values asynchronously.

## Configuration
- SCHED_TIMEOUT_EN defined: a stall counter runs in ISSUE and WAIT.
  - It clears on any cmd handshake or accepted beat.
  - On reaching TIMEOUT_CYCLES, pulse req_err[grant_id] instead of req_done, drop cmd_valid, and return to IDLE. rr_ptr still advances.
- SCHED_TIMEOUT_EN undefined: no counter exists, req_err is tied to 0, and the block waits indefinitely.

## Structure
- Shared package pattern_pkg holds:
  - state enum
  - CMD_WIDTH=96
  - command field offsets (LEN_LSB=64, ADDR_LSB=32)
  - a function packing {length, address} into cmd_data
- One sub-module, rr_arbiter (NUM_REQ): request vector + rr_ptr → one-hot grant and encoded index. It is reusable elsewhere in the design.

## Test plan
- Single request, req 0, addr 0x1000, length 1024, MAX_CHUNK 4096, cmd_ready=1, no waitrequest → one command with cmd_data[95:64]=1024 and [63:32]=0x1000; req_done[0] one cycle after the 256th accepted beat.
- Chunking, length 10000, MAX_CHUNK 4096 → three commands of lengths 4096, 4096, 1808 at addresses A, A+4096, A+8192; exactly one req_done.
- Fairness, all four req_valid held high, lengths 16 → grant order 0,1,2,3,0; no requester is granted twice before the others.
- Backpressure, random mon_waitrequest (50%) and cmd_ready delayed 5 cycles → cmd_data stable while cmd_valid=1; beat count exact; req_done only after the last accepted beat.
- Zero length, req 2 with length 0 → req_ready[2] pulse, no cmd_valid, req_done[2] one cycle later.
- Reset mid-WAIT, and timeout with SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=64 and no beats:
  - reset → all outputs at reset values; no done or err pulse.
  - timeout → req_err[grant_id] 64 cycles after the last activity, then IDLE.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types and command packing for the pattern writer command scheduler.
package pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sched_state_e;

  localparam int CMD_WIDTH = 96;
  localparam int FIELD_W   = 32;
  localparam int LEN_LSB   = 64;
  localparam int ADDR_LSB  = 32;

  // Writer command word: {length, address, 32'h0}.
  function automatic logic [CMD_WIDTH-1:0] pack_cmd(input logic [FIELD_W-1:0] len,
                                                    input logic [FIELD_W-1:0] addr);
    logic [CMD_WIDTH-1:0] c;
    c = '0;
    c[LEN_LSB +: FIELD_W]  = len;
    c[ADDR_LSB +: FIELD_W] = addr;
    return c;
  endfunction

endpackage

// File: rtl/pattern_cmd_scheduler_if.sv
// Requester, command-sink and write-monitor signals of the scheduler.
// slave: scheduler side; master: requesters / writer side.
interface pattern_cmd_scheduler_if #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int LENGTH_WIDTH  = 32
);
  import pattern_pkg::*;

  logic [NUM_REQ-1:0]                    req_valid;
  logic [NUM_REQ-1:0]                    req_ready;
  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][LENGTH_WIDTH-1:0]  req_length;
  logic [NUM_REQ-1:0]                    req_done;
  logic [NUM_REQ-1:0]                    req_err;
  logic [CMD_WIDTH-1:0]                  cmd_data;
  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic                                  mon_write;
  logic                                  mon_waitrequest;

  modport slave (
    input  req_valid, req_addr, req_length, cmd_ready, mon_write, mon_waitrequest,
    output req_ready, req_done, req_err, cmd_data, cmd_valid
  );

  modport master (
    output req_valid, req_addr, req_length, cmd_ready, mon_write, mon_waitrequest,
    input  req_ready, req_done, req_err, cmd_data, cmd_valid
  );
endinterface

// File: rtl/pattern_cmd_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping.
// Produces a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_any
);
  logic [2*NUM_REQ-1:0] req_sh;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IW-1:0]        off;
  logic [IW:0]          sum;

  always_comb begin
    // Rotate so ptr sits at bit 0, then take the lowest set bit.
    req_sh  = {req, req} >> ptr;
    req_rot = req_sh[NUM_REQ-1:0];
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
    gnt_any = |req;
    gnt_idx = sum[IW-1:0];
    gnt     = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/pattern_cmd_scheduler.sv
// Round-robin command scheduler: splits requests into <=MAX_CHUNK commands, one outstanding.
// Optional stall timeout enabled by defining SCHED_TIMEOUT_EN.
module pattern_cmd_scheduler
  import pattern_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int LENGTH_WIDTH      = 32,
  parameter int BYTE_ENABLE_WIDTH = 4,
  parameter int MAX_CHUNK         = 4096,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int IW                = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  pattern_cmd_scheduler_if.slave    bus,
  output logic                      busy,
  output logic [IW-1:0]             grant_id
);
  localparam int AW      = ADDRESS_WIDTH;
  localparam int LW      = LENGTH_WIDTH;
  localparam int BEAT_SH = $clog2(BYTE_ENABLE_WIDTH);

  if (TIMEOUT_CYCLES < 1 || (MAX_CHUNK % BYTE_ENABLE_WIDTH) != 0) begin : g_cfg_err
    $error("pattern_cmd_scheduler: invalid TIMEOUT_CYCLES or MAX_CHUNK");
  end

  sched_state_e  state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [LW-1:0] beats_q, beats_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [LW-1:0]      chunk;
  logic               beat_acc;
  logic               activity;
  logic               timeout;
  logic [NUM_REQ-1:0] gid_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // chunk depends only on rem_q, which holds until the last beat of the chunk.
  assign chunk    = (rem_q > LW'(MAX_CHUNK)) ? LW'(MAX_CHUNK) : rem_q;
  assign beat_acc = (state_q == ST_WAIT) && bus.mon_write && !bus.mon_waitrequest;
  assign activity = ((state_q == ST_ISSUE) && bus.cmd_ready) || beat_acc;
  assign gid_oh   = NUM_REQ'(1) << gid_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gid_d    = arb_idx;
          addr_d   = bus.req_addr[arb_idx];
          rem_d    = bus.req_length[arb_idx];
          rr_ptr_d = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d  = (bus.req_length[arb_idx] == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.cmd_ready) begin
          beats_d = chunk >> BEAT_SH;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (beat_acc) begin
          beats_d = beats_q - 1'b1;
          if (beats_q <= LW'(1)) begin
            addr_d  = addr_q + AW'(chunk);
            rem_d   = rem_q - chunk;
            state_d = (rem_q == chunk) ? ST_DONE : ST_ISSUE;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;

  // Timeout fires in the TIMEOUT_CYCLES-th consecutive idle cycle of ISSUE/WAIT.
  always_comb begin
    stall_d = '0;
    timeout = 1'b0;
    if ((state_q == ST_ISSUE || state_q == ST_WAIT) && !activity) begin
      if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.req_err = timeout ? gid_oh : '0;
`else
  assign timeout     = 1'b0;
  assign bus.req_err = '0;
`endif

  // Grant is gated by reset so a held req_valid cannot pulse req_ready while in reset.
  assign bus.req_ready = (reset && state_q == ST_IDLE) ? arb_gnt : '0;
  assign bus.req_done  = (state_q == ST_DONE) ? gid_oh : '0;
  assign bus.cmd_valid = (state_q == ST_ISSUE);
  assign bus.cmd_data  = (state_q == ST_ISSUE) ? pack_cmd(FIELD_W'(chunk), FIELD_W'(addr_q)) : '0;
  assign busy          = (state_q != ST_IDLE);
  assign grant_id      = gid_q;

endmodule

// File: tb/tb_pattern_cmd_scheduler.sv
// Directed bench for pattern_cmd_scheduler with a writer model that turns each
// accepted command into length/4 write beats.
module tb_pattern_cmd_scheduler;
  logic       clk;
  logic       reset;
  logic       busy;
  logic [1:0] grant_id;

  pattern_cmd_scheduler_if #(.NUM_REQ(4), .ADDRESS_WIDTH(32), .LENGTH_WIDTH(32)) bus();

  pattern_cmd_scheduler #(
    .NUM_REQ(4), .ADDRESS_WIDTH(32), .LENGTH_WIDTH(32), .BYTE_ENABLE_WIDTH(4),
    .MAX_CHUNK(4096), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bench knobs, written only by the main thread.
  logic wr_mute = 1'b0;
  logic wr_rand = 1'b0;
  int   rdy_delay = 0;

  // Monitor state, written only by the negedge monitor.
  logic [3:0]  gnt_q[$];
  logic [3:0]  done_q[$];
  logic [3:0]  err_q[$];
  logic [95:0] cmd_q[$];
  int cyc = 0, beats_seen = 0, writer_left = 0, cv_age = 0, unstable = 0;
  int grant_cyc = 0, hs_cyc = 0, done_cyc = 0, err_cyc = 0, last_beat_cyc = 0, done_beats = 0;
  logic        cv_prev = 1'b0;
  logic [95:0] cd_prev = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      writer_left = 0;
      cv_age      = 0;
      cv_prev     = 1'b0;
    end else begin
      if (bus.req_ready != 0) begin gnt_q.push_back(bus.req_ready); grant_cyc = cyc; end
      if (bus.req_done != 0) begin done_q.push_back(bus.req_done); done_cyc = cyc; done_beats = beats_seen; end
      if (bus.req_err != 0) begin err_q.push_back(bus.req_err); err_cyc = cyc; end
      if (bus.cmd_valid) begin
        if (cv_prev && bus.cmd_data != cd_prev) unstable++;
        if (bus.cmd_ready) begin
          cmd_q.push_back(bus.cmd_data);
          writer_left += int'(bus.cmd_data[95:64]) / 4;
          hs_cyc  = cyc;
          cv_prev = 1'b0;
          cv_age  = 0;
        end else begin
          cv_prev = 1'b1;
          cd_prev = bus.cmd_data;
          cv_age++;
        end
      end else begin
        cv_prev = 1'b0;
        cv_age  = 0;
      end
      if (bus.mon_write && !bus.mon_waitrequest) begin
        beats_seen++;
        writer_left--;
        last_beat_cyc = cyc;
      end
    end
  end

  // Writer / command-sink drive, just after each rising edge.
  always @(posedge clk) begin
    #1;
    bus.mon_write       = reset && (writer_left > 0) && !wr_mute;
    bus.mon_waitrequest = wr_rand && ($urandom_range(1, 0) == 1);
    bus.cmd_ready       = (cv_age >= rdy_delay);
  end

  // Raise req_valid for mask, hold until ngr grants are seen, then withdraw.
  task automatic req_go(input logic [3:0] mask, input int ngr);
    int g0 = gnt_q.size();
    int n  = 0;
    @(posedge clk); #2;
    bus.req_valid = mask;
    while (gnt_q.size() < g0 + ngr && n < 20000) begin @(negedge clk); #1; n++; end
    chk("grant_count", gnt_q.size() - g0, ngr);
    @(posedge clk); #2;
    bus.req_valid = '0;
  endtask

  task automatic wait_dones(input int target);
    int n = 0;
    while (done_q.size() < target && n < 20000) begin @(negedge clk); #1; n++; end
    if (done_q.size() < target) chk("done_timeout", done_q.size(), target);
  endtask

  logic [3:0] fair_exp [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  int g0, d0, b0, c0, e0;

  initial begin
    reset = 1'b0;
    bus.req_valid  = 4'b0100;
    bus.req_addr   = '0;
    bus.req_length = '0;
    repeat (3) @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_data", bus.cmd_data, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_done", bus.req_done, 0);
    chk("rst_err", bus.req_err, 0);
    chk("rst_grant_id", grant_id, 0);
    bus.req_valid = '0;
    @(posedge clk); #2;
    reset = 1'b1;

    // Single request, one command.
    g0 = gnt_q.size(); d0 = done_q.size(); b0 = beats_seen; c0 = cmd_q.size();
    bus.req_addr[0] = 32'h1000; bus.req_length[0] = 32'd1024;
    req_go(4'b0001, 1);
    chk("t1_ready", gnt_q[g0], 4'b0001);
    wait_dones(d0 + 1);
    chk("t1_cmd_latency", hs_cyc - grant_cyc, 1);
    chk("t1_ncmd", cmd_q.size() - c0, 1);
    chk("t1_cmd", cmd_q[c0], {32'd1024, 32'h1000, 32'h0});
    chk("t1_done", done_q[d0], 4'b0001);
    chk("t1_beats", done_beats - b0, 256);
    chk("t1_done_lat", done_cyc - last_beat_cyc, 1);

    // Chunking: 10000 bytes -> 4096, 4096, 1808.
    d0 = done_q.size(); b0 = beats_seen; c0 = cmd_q.size();
    bus.req_addr[1] = 32'h2000_0000; bus.req_length[1] = 32'd10000;
    req_go(4'b0010, 1);
    wait_dones(d0 + 1);
    repeat (3) @(negedge clk); #1;
    chk("t2_ncmd", cmd_q.size() - c0, 3);
    chk("t2_cmd0", cmd_q[c0],     {32'd4096, 32'h2000_0000, 32'h0});
    chk("t2_cmd1", cmd_q[c0 + 1], {32'd4096, 32'h2000_1000, 32'h0});
    chk("t2_cmd2", cmd_q[c0 + 2], {32'd1808, 32'h2000_2000, 32'h0});
    chk("t2_ndone", done_q.size() - d0, 1);
    chk("t2_beats", done_beats - b0, 2500);

    // Zero length: grant then done, no command.
    g0 = gnt_q.size(); d0 = done_q.size(); c0 = cmd_q.size();
    bus.req_addr[2] = 32'h7777_0000; bus.req_length[2] = 32'd0;
    req_go(4'b0100, 1);
    wait_dones(d0 + 1);
    chk("t3_ready", gnt_q[g0], 4'b0100);
    chk("t3_done", done_q[d0], 4'b0100);
    chk("t3_done_lat", done_cyc - grant_cyc, 1);
    chk("t3_nocmd", cmd_q.size() - c0, 0);

    // Address wraps past 2^32.
    d0 = done_q.size(); c0 = cmd_q.size();
    bus.req_addr[3] = 32'hFFFF_F000; bus.req_length[3] = 32'd8192;
    req_go(4'b1000, 1);
    wait_dones(d0 + 1);
    chk("t4_cmd0", cmd_q[c0],     {32'd4096, 32'hFFFF_F000, 32'h0});
    chk("t4_cmd1", cmd_q[c0 + 1], {32'd4096, 32'h0000_0000, 32'h0});
    chk("t4_done", done_q[d0], 4'b1000);

    // Fairness: all four held, rr_ptr is back at 0.
    g0 = gnt_q.size(); d0 = done_q.size();
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i]   = 32'h4000 + 32'(i) * 32'h100;
      bus.req_length[i] = 32'd16;
    end
    req_go(4'b1111, 5);
    wait_dones(d0 + 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t5_order%0d", k), gnt_q[g0 + k], fair_exp[k]);

    // Backpressure: 50% waitrequest, cmd_ready after 5 cycles.
    wr_rand = 1'b1; rdy_delay = 5;
    d0 = done_q.size(); b0 = beats_seen; c0 = cmd_q.size();
    bus.req_addr[0] = 32'h3000; bus.req_length[0] = 32'd4160;
    req_go(4'b0001, 1);
    wait_dones(d0 + 1);
    chk("t6_cmd0", cmd_q[c0],     {32'd4096, 32'h3000, 32'h0});
    chk("t6_cmd1", cmd_q[c0 + 1], {32'd64,   32'h4000, 32'h0});
    chk("t6_beats", done_beats - b0, 1040);
    chk("t6_done_lat", done_cyc - last_beat_cyc, 1);
    chk("t6_stable", unstable, 0);
    wr_rand = 1'b0; rdy_delay = 0;

    // Reset in the middle of WAIT.
    d0 = done_q.size(); e0 = err_q.size(); b0 = beats_seen;
    bus.req_addr[1] = 32'h5000; bus.req_length[1] = 32'd1024;
    req_go(4'b0010, 1);
    for (int n = 0; n < 200 && beats_seen - b0 < 10; n++) begin @(negedge clk); #1; end
    chk("t7_in_wait", busy, 1);
    bus.req_valid = 4'b0100;
    reset = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_cmd_valid", bus.cmd_valid, 0);
    chk("t7_cmd_data", bus.cmd_data, 0);
    chk("t7_ready", bus.req_ready, 0);
    chk("t7_grant_id", grant_id, 0);
    repeat (3) @(negedge clk);
    bus.req_valid = '0;
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (5) @(negedge clk); #1;
    chk("t7_no_done", done_q.size() - d0, 0);
    chk("t7_no_err", err_q.size() - e0, 0);

    // rr_ptr restarts at 0 after reset: {3,0} pending grants 0.
    g0 = gnt_q.size(); d0 = done_q.size();
    bus.req_length[0] = 32'd16; bus.req_length[3] = 32'd16;
    req_go(4'b1001, 1);
    chk("t8_ptr_reset", gnt_q[g0], 4'b0001);
    wait_dones(d0 + 1);

`ifdef SCHED_TIMEOUT_EN
    // Timeout: writer never produces beats.
    wr_mute = 1'b1;
    d0 = done_q.size(); e0 = err_q.size();
    bus.req_addr[1] = 32'h6000; bus.req_length[1] = 32'd64;
    req_go(4'b0010, 1);
    for (int n = 0; n < 500 && err_q.size() == e0; n++) begin @(negedge clk); #1; end
    chk("t9_nerr", err_q.size() - e0, 1);
    chk("t9_err", err_q[e0], 4'b0010);
    chk("t9_err_lat", err_cyc - hs_cyc, 64);
    @(negedge clk); #1;
    chk("t9_idle", busy, 0);
    chk("t9_no_done", done_q.size() - d0, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
